trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/riscv_trace_pkg.sv | 17 +
 rtl/trace_capture_if.sv | 28 ++
 rtl/trace_fifo.sv | 75 +++++++
 rtl/trace_capture.sv | 86 ++++++++
 tb/tb_trace_capture.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_trace_pkg.sv
// rtl/riscv_trace_pkg.sv - shared types and constants for the retire-trace capture block
// Contents: trace_rec_t (pc/instr/cycle record), TRACE_DEPTH_DEFAULT, LAST_PC_RESET.
package riscv_trace_pkg;

    localparam int TRACE_DEPTH_DEFAULT = 16;

    // Value last_pc takes out of reset; no real fetch address matches it,
    // so the first record after reset is never suppressed.
    localparam logic [31:0] LAST_PC_RESET = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cycle;
    } trace_rec_t;

endpackage

// File: rtl/trace_capture_if.sv
// rtl/trace_capture_if.sv - retire-record input and head-record output bundle
// Signals: in_valid/in_pc/in_instr/in_cycle (core side),
//          out_valid/out_ready/out_pc/out_instr/out_cycle (consumer side).
// Modports: master = core + consumer (drives in_*, out_ready), slave = capture block.
interface trace_capture_if;

    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [31:0] in_cycle;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_cycle;

    modport master (
        output in_valid, in_pc, in_instr, in_cycle, out_ready,
        input  out_valid, out_pc, out_instr, out_cycle
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_cycle, out_ready,
        output out_valid, out_pc, out_instr, out_cycle
    );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through record FIFO with pointers and level
// Ports: clk, reset (async, active-high), push/wr_data (write side), pop/rd_data (head),
//        level/full/empty (occupancy). rd_data reads zero while empty.
module trace_fifo
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  trace_rec_t             wr_data,
    output trace_rec_t             rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_LVL = (PW + 1)'(DEPTH);

    // Storage is deliberately left out of reset; only the pointers and level matter.
    trace_rec_t    mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   level_q,  level_d;
    logic          do_push,  do_pop;

    always_comb begin
        do_pop   = pop && (level_q != '0);
        // A full FIFO still takes a write when the head leaves in the same cycle.
        do_push  = push && ((level_q != FULL_LVL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Pointers wrap for free because DEPTH is a power of two.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (PW + 1)'(1);
            2'b01:   level_d = level_q - (PW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign level   = level_q;
    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - retire-trace capture: accepts core retire records into a FIFO, counts overflow drops
// Ports: clk, reset (async, active-high), bus (trace_capture_if.slave: in_* records in,
//        out_* head record with out_valid/out_ready), level/full/empty, drop_count (saturating).
// Build option: TRACE_FILTER_EN enables stall suppression (a record whose pc equals the
//        last pushed pc is discarded without counting as a drop).
module trace_capture
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    trace_capture_if.slave         bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       drop_count
);

    trace_rec_t       in_rec;
    trace_rec_t       head_rec;
    logic             pop;
    logic             push;
    logic             drop;
    logic             filtered;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

`ifdef TRACE_FILTER_EN
    logic [31:0]      last_pc_q, last_pc_d;
`endif

    always_comb begin
        in_rec   = '{pc: bus.in_pc, instr: bus.in_instr, cycle: bus.in_cycle};
        pop      = !empty && bus.out_ready;
        filtered = 1'b0;
`ifdef TRACE_FILTER_EN
        // A stalled core re-presents the same pc; keep only the first copy.
        filtered = bus.in_valid && (bus.in_pc == last_pc_q);
`endif
        push         = bus.in_valid && !filtered && (!full || pop);
        drop         = bus.in_valid && !filtered && !push;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end
`ifdef TRACE_FILTER_EN
        last_pc_d = push ? bus.in_pc : last_pc_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
`ifdef TRACE_FILTER_EN
            last_pc_q    <= LAST_PC_RESET;
`endif
        end else begin
            drop_count_q <= drop_count_d;
`ifdef TRACE_FILTER_EN
            last_pc_q    <= last_pc_d;
`endif
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_rec),
        .rd_data (head_rec),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign bus.out_valid = !empty;
    assign bus.out_pc    = head_rec.pc;
    assign bus.out_instr = head_rec.instr;
    assign bus.out_cycle = head_rec.cycle;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - scoreboard bench for trace_capture: directed scenarios plus random traffic
module tb_trace_capture;
    import riscv_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int MAXD  = (1 << CNT_W) - 1;
`ifdef TRACE_FILTER_EN
    localparam int EXP_FILT_LEVEL = 2;
`else
    localparam int EXP_FILT_LEVEL = 4;
`endif

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] drop_count;

    trace_capture_if bus ();

    trace_capture #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    trace_rec_t  sb_q[$];
    int          mdl_level = 0;
    int          mdl_drop  = 0;
    logic [31:0] last_pc   = 32'hFFFF_FFFF;
    int          pop_cnt   = 0;
    logic [31:0] last_out_pc = '0;
    int          cyc_ctr   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares DUT state and head record with the model between clock edges.
    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid", 64'(bus.out_valid), 64'(mdl_level > 0));
            check("level", 64'(level), 64'(mdl_level));
            check("empty", 64'(empty), 64'(mdl_level == 0));
            check("full", 64'(full), 64'(mdl_level == DEPTH));
            check("drop_count", 64'(drop_count), 64'(mdl_drop));
            if (mdl_level == 0) begin
                check("empty_out_pc_zero", 64'(bus.out_pc), 64'(0));
            end
            if (bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_underflow: DUT shows pc %0h, scoreboard empty", bus.out_pc);
                end else begin
                    check("head_pc", 64'(bus.out_pc), 64'(sb_q[0].pc));
                    check("head_instr", 64'(bus.out_instr), 64'(sb_q[0].instr));
                    check("head_cycle", 64'(bus.out_cycle), 64'(sb_q[0].cycle));
                    if (bus.out_ready) begin
                        last_out_pc = sb_q[0].pc;
                        void'(sb_q.pop_front());
                        pop_cnt++;
                    end
                end
            end
        end
    end

    // One clock of stimulus; the model decides acceptance from occupancy alone.
    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
        trace_rec_t r;
        logic pop_now, filt, acc;
        int nxt_level, nxt_drop;
        r.pc    = pc;
        r.instr = $urandom;
        r.cycle = 32'(cyc_ctr);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = r.instr;
        bus.in_cycle  = r.cycle;
        bus.out_ready = rdy;
        pop_now = (mdl_level > 0) && rdy;
        filt    = 1'b0;
`ifdef TRACE_FILTER_EN
        filt = v && (pc == last_pc);
`endif
        acc = v && !filt && ((mdl_level < DEPTH) || pop_now);
        if (acc) begin
            sb_q.push_back(r);
            last_pc = pc;
        end
        nxt_level = mdl_level + (acc ? 1 : 0) - (pop_now ? 1 : 0);
        nxt_drop  = mdl_drop;
        if (v && !filt && !acc && mdl_drop < MAXD) nxt_drop++;
        @(posedge clk);
        #1;
        mdl_level = nxt_level;
        mdl_drop  = nxt_drop;
        cyc_ctr++;
    endtask

    // Reset for one cycle with a valid record presented; nothing may survive.
    task automatic do_reset();
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h0000_1234;
        bus.in_instr  = 32'h0;
        bus.in_cycle  = 32'h0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full", 64'(full), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_drop", 64'(drop_count), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        sb_q.delete();
        mdl_level = 0;
        mdl_drop  = 0;
        last_pc   = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int p0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.in_cycle = '0; bus.out_ready = 1'b0;
        #2;
        do_reset();

        // Three records held, then drained in order.
        drive(1, 32'h0, 0); drive(1, 32'h4, 0); drive(1, 32'h8, 0);
        drive(0, 32'h0, 0);
        check("seq3_level", 64'(level), 64'(3));
        check("seq3_head", 64'(bus.out_pc), 64'(0));
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 1);
        check("seq3_empty", 64'(empty), 64'(1));

        // Overflow: 20 pushes into a 16-deep FIFO.
        do_reset();
        for (int i = 0; i < 20; i++) drive(1, 32'h1000 + 32'(i) * 4, 0);
        check("ovf_full", 64'(full), 64'(1));
        check("ovf_level", 64'(level), 64'(16));
        check("ovf_drop", 64'(drop_count), 64'(4));
        check("ovf_head", 64'(bus.out_pc), 64'(32'h1000));
        p0 = pop_cnt;
        for (int i = 0; i < 18; i++) drive(0, 32'h0, 1);
        check("ovf_drained", 64'(pop_cnt - p0), 64'(16));

        // Full with simultaneous pop and push.
        for (int i = 0; i < 16; i++) drive(1, 32'h2000 + 32'(i) * 4, 0);
        drive(1, 32'hBEEF0, 1);
        check("fullpp_drop", 64'(drop_count), 64'(4));
        check("fullpp_level", 64'(level), 64'(16));
        for (int i = 0; i < 17; i++) drive(0, 32'h0, 1);
        check("fullpp_last_out", 64'(last_out_pc), 64'(32'hBEEF0));

        // Latency-one appearance in an empty FIFO.
        do_reset();
        drive(1, 32'h100, 0);
        check("lat1_valid", 64'(bus.out_valid), 64'(1));
        check("lat1_pc", 64'(bus.out_pc), 64'(32'h100));

        // Reset mid-drain.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 32'h3000 + 32'(i) * 4, 0);
        drive(0, 32'h0, 1); drive(0, 32'h0, 1);
        do_reset();
        drive(0, 32'h0, 0);

        // Repeated pc: filtered or stored depending on the build.
        do_reset();
        drive(1, 32'h10, 0); drive(1, 32'h10, 0); drive(1, 32'h10, 0); drive(1, 32'h14, 0);
        check("filt_level", 64'(level), 64'(EXP_FILT_LEVEL));
        check("filt_drop", 64'(drop_count), 64'(0));
        for (int i = 0; i < 5; i++) drive(0, 32'h0, 1);

        // Random traffic with a small pc alphabet so repeats occur.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            drive(($urandom_range(0, 3) != 0), 32'($urandom_range(0, 7)) * 4, ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 32'h0, 1);
        check("final_empty", 64'(empty), 64'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
